fml_bram: RTL

FML_BRAM -- requirements
Module: fml_bram

---
 rtl/fml_pkg.sv | 18 +
 rtl/fml_bram_mem.sv | 42 ++++
 rtl/fml_bram.sv | 112 +++++++++++
 3 files changed

// File: rtl/fml_pkg.sv
// Shared FML bus widths and the BRAM controller state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fml_pkg;

  localparam int FML_ADR_W = 26;
  localparam int FML_DAT_W = 32;
  localparam int FML_SEL_W = 4;

  // Request lifecycle: accept, count down, pulse ack, one dead cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_TURN = 2'd3
  } fml_state_t;

endpackage

// File: rtl/fml_bram_mem.sv
// Single-port 32-bit word RAM with per-byte write enables.
// Latency: 1 cycle read; o_rdat only changes on a cycle with i_re=1.
// Backpressure: none, one access per cycle; array contents survive reset.
module fml_bram_mem
  import fml_pkg::*;
#(
  parameter int ADR_WIDTH = 12
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [ADR_WIDTH-1:0] i_adr,
  input  logic                 i_re,
  input  logic                 i_we,
  input  logic [FML_SEL_W-1:0] i_sel,
  input  logic [FML_DAT_W-1:0] i_wdat,
  output logic [FML_DAT_W-1:0] o_rdat
);

  logic [FML_DAT_W-1:0] r_mem [0:(1<<ADR_WIDTH)-1];
  logic [FML_DAT_W-1:0] r_rdat;

  // Byte-masked write; the array has no reset so contents persist through sys_rst_n.
  always_ff @(posedge sys_clk) begin
    for (int b = 0; b < FML_SEL_W; b++) begin
      if (i_we && i_sel[b]) begin
        r_mem[i_adr][8*b +: 8] <= i_wdat[8*b +: 8];
      end
    end
  end

  // Read register holds its value between read strobes; reset clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rdat <= '0;
    end else if (i_re) begin
      r_rdat <= r_mem[i_adr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/fml_bram.sv
// FML slave backed by on-chip RAM; FML_BRAM_WRITE_EN enables the write path (undefined = read-only, writes acked as no-ops).
// Latency: ack LATENCY cycles after the strobe is sampled in IDLE; one-cycle ack, then one dead cycle.
// Backpressure: master holds fml_stb until fml_ack; strobe ignored outside IDLE, so requests are spaced by LATENCY+2.
module fml_bram
  import fml_pkg::*;
#(
  parameter int ADR_WIDTH = 12,
  parameter int LATENCY   = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [FML_ADR_W-1:0] fml_adr,
  input  logic                 fml_stb,
  input  logic                 fml_we,
  input  logic [FML_SEL_W-1:0] fml_sel,
  input  logic [FML_DAT_W-1:0] fml_do,
  output logic [FML_DAT_W-1:0] fml_di,
  output logic                 fml_ack
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  fml_state_t           r_state;
  logic [3:0]           r_cnt;
  logic [ADR_WIDTH-1:0] r_adr;
  logic                 r_we;
  logic [FML_SEL_W-1:0] r_sel;
  logic [FML_DAT_W-1:0] r_dat;
  logic                 r_ack;
  logic                 r_ready;

  logic                 w_start;
  logic                 w_to_ack;
  logic                 w_is_wr;
  logic                 w_mem_re;
  logic                 w_mem_we;
  logic [ADR_WIDTH-1:0] w_adr_in;
  logic [ADR_WIDTH-1:0] w_mem_adr;
  logic                 w_unused_adr;

  // Byte-offset bits and bits above the RAM size are dropped, so addresses alias.
  assign w_adr_in     = fml_adr[ADR_WIDTH+1:2];
  assign w_unused_adr = ^{fml_adr[FML_ADR_W-1:ADR_WIDTH+2], fml_adr[1:0]};

  // r_ready keeps the first sample off the first edge after reset release.
  assign w_start  = (r_state == ST_IDLE) && r_ready && fml_stb;
  assign w_to_ack = (w_start && (LATENCY == 1)) || ((r_state == ST_WAIT) && (r_cnt == 4'd1));
  assign w_is_wr  = w_start ? fml_we : r_we;

  // RAM is addressed from the bus while idle, from the latched request otherwise.
  // The read fires on the edge entering ACK so data and ack appear together.
  assign w_mem_adr = (r_state == ST_IDLE) ? w_adr_in : r_adr;
  assign w_mem_re  = w_to_ack && !w_is_wr;
`ifdef FML_BRAM_WRITE_EN
  assign w_mem_we  = (r_state == ST_ACK) && r_we;
`else
  assign w_mem_we  = 1'b0;
`endif

  // Request FSM with registered ack; reset drops any in-flight request.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_ack   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_ack   <= w_to_ack;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_adr   <= w_adr_in;
            r_we    <= fml_we;
            r_sel   <= fml_sel;
            r_dat   <= fml_do;
            r_cnt   <= CNT_LOAD;
            r_state <= (LATENCY == 1) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_ACK;
          end
        end
        ST_ACK:  r_state <= ST_TURN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fml_bram_mem #(
    .ADR_WIDTH (ADR_WIDTH)
  ) u_mem (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_adr     (w_mem_adr),
    .i_re      (w_mem_re),
    .i_we      (w_mem_we),
    .i_sel     (r_sel),
    .i_wdat    (r_dat),
    .o_rdat    (fml_di)
  );

  assign fml_ack = r_ack;

endmodule
